// File: rtl/pin_debounce.sv
// Pin input conditioner: two-flop synchronizer, stability qualifier FSM,
// registered clean level, single-cycle rise/fall pulses and a wrapping
// qualified-edge counter.
module pin_debounce #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             d_out,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int unsigned     SC_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_t;

  logic             s1;
  logic             s2;
  state_t           state_q;
  state_t           state_d;
  logic [SC_W-1:0]  sc_q;
  logic [SC_W-1:0]  sc_d;
  logic             d_out_d;
  logic             rise_d;
  logic             fall_d;
  logic             busy_d;
  logic             edge_hit;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] edge_cnt_d;

  // Two-flop synchronizer; s2 is the only view of the pin used below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // Next-state, stability count and registered-output next values.
  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    d_out_d  = d_out;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    edge_hit = 1'b0;

    if (!en) begin
      state_d = IDLE;
      sc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s2 != d_out) begin
            state_d = QUAL;
            sc_d    = SC_W'(1);
          end else begin
            sc_d = '0;
          end
        end
        QUAL: begin
          if (s2 == d_out) begin
            // Reverted before qualifying: drop the candidate.
            state_d = IDLE;
            sc_d    = '0;
          end else if (sc_q == SC_MAX) begin
            d_out_d  = ~d_out;
            rise_d   = ~d_out;
            fall_d   = d_out;
            edge_hit = 1'b1;
            state_d  = IDLE;
            sc_d     = '0;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          sc_d    = '0;
        end
      endcase
    end

    // Clear takes effect before the increment of a same-cycle edge.
    cnt_base   = clr_cnt ? '0 : edge_cnt;
    edge_cnt_d = edge_hit ? cnt_base + CNT_W'(1) : cnt_base;
    busy_d     = (state_d == QUAL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sc_q     <= '0;
      d_out    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      busy     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      d_out    <= d_out_d;
      rise     <= rise_d;
      fall     <= fall_d;
      busy     <= busy_d;
      edge_cnt <= edge_cnt_d;
    end
  end

endmodule

// File: tb/tb_pin_debounce.sv
// Bench for pin_debounce with STABLE_CYCLES=4, CNT_W=2.
module tb_pin_debounce;

  localparam int unsigned SC = 4;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic          pin;
  logic          en;
  logic          clr_cnt;
  logic          d_out;
  logic          rise;
  logic          fall;
  logic          busy;
  logic [CW-1:0] edge_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench-side model of the observable level and count.
  logic          d_exp;
  logic [CW-1:0] cnt_exp;

  typedef struct {
    logic       p;
    logic       e;
    logic       c;
    logic [5:0] exp; // {d_out, rise, fall, busy, edge_cnt[1:0]}
  } vec_t;

  vec_t vecs[$];

  pin_debounce #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin      (pin),
    .en       (en),
    .clr_cnt  (clr_cnt),
    .d_out    (d_out),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy),
    .edge_cnt (edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic p, input logic e, input logic c,
                              input logic d, input logic r, input logic f,
                              input logic b, input logic [1:0] cnt, input int rep);
    vec_t v;
    v.p   = p;
    v.e   = e;
    v.c   = c;
    v.exp = {d, r, f, b, cnt};
    for (int i = 0; i < rep; i++) vecs.push_back(v);
  endfunction

  function automatic logic [5:0] obs();
    return {d_out, rise, fall, busy, edge_cnt};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until a rise or fall pulse appears; n = step index or -1.
  task automatic run_until_edge(output int n, output logic r, output logic f,
                                output logic [CW-1:0] c);
    n = -1;
    r = 1'b0;
    f = 1'b0;
    c = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rise || fall) begin
        n = i;
        r = rise;
        f = fall;
        c = edge_cnt;
        break;
      end
    end
  endtask

  // Drive pin to the opposite level and check a fully qualified edge.
  task automatic expect_edge(input string name, input int exp_n);
    int            n;
    logic          r;
    logic          f;
    logic [CW-1:0] c;
    logic          lvl;
    lvl = ~d_exp;
    pin = lvl;
    run_until_edge(n, r, f, c);
    d_exp   = lvl;
    cnt_exp = cnt_exp + CW'(1);
    check({name, "_latency"}, n, exp_n);
    check({name, "_pulse"}, int'({r, f}), int'({lvl, ~lvl}));
    check({name, "_cnt"}, int'(c), int'(cnt_exp));
    step();
    check({name, "_single"}, int'({rise, fall}), 0);
    check({name, "_level"}, int'(d_out), int'(d_exp));
  endtask

  initial begin
    int            n;
    int            nr;
    int            nf;
    int            viol;
    logic          r;
    logic          f;
    logic [CW-1:0] c;
    logic [CW-1:0] wrap_seq [5];

    rst_n   = 1'b0;
    pin     = 1'b0;
    en      = 1'b1;
    clr_cnt = 1'b0;
    d_exp   = 1'b0;
    cnt_exp = '0;

    // Reset values.
    step();
    step();
    check("reset_outputs", int'(obs()), 0);
    rst_n = 1'b1;
    step();
    step();
    step();
    check("idle_after_reset", int'(obs()), 0);

    // Clean rise, clean fall, clear alone, 3-cycle glitch.
    add(1, 1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 0, 1, 0, 4);
    add(1, 1, 0, 1, 1, 0, 0, 1, 1);
    add(1, 1, 0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 0, 0, 0, 1, 2);
    add(0, 1, 0, 1, 0, 0, 1, 1, 4);
    add(0, 1, 0, 0, 0, 1, 0, 2, 1);
    add(0, 1, 0, 0, 0, 0, 0, 2, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0, 0, 6);

    for (int i = 0; i < vecs.size(); i++) begin
      pin     = vecs[i].p;
      en      = vecs[i].e;
      clr_cnt = vecs[i].c;
      step();
      n_tests++;
      if (obs() != vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec[%0d]: got {d,r,f,b,cnt}=%b expected %b", i, obs(), vecs[i].exp);
      end
    end
    clr_cnt = 1'b0;

    // 1-on/1-off bounce for 20 cycles, then held high.
    nr = 0;
    nf = 0;
    n  = -1;
    for (int i = 0; i < 40; i++) begin
      pin = (i < 20) ? ((i % 2) == 0) : 1'b1;
      step();
      if (rise) begin
        nr++;
        n = i;
      end
      if (fall) nf++;
    end
    check("bounce_rise_count", nr, 1);
    check("bounce_fall_count", nf, 0);
    check("bounce_rise_step", n, 26);
    check("bounce_cnt", int'(edge_cnt), 1);
    d_exp = 1'b1;

    // Counter wrap after a clear.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    cnt_exp = '0;
    check("clr_before_wrap", int'(edge_cnt), 0);
    wrap_seq[0] = 2'd1;
    wrap_seq[1] = 2'd2;
    wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0;
    wrap_seq[4] = 2'd1;
    for (int k = 0; k < 5; k++) begin
      expect_edge($sformatf("wrap%0d", k), 6);
      check($sformatf("wrap%0d_seq", k), int'(edge_cnt), int'(wrap_seq[k]));
    end

    // Clear coinciding with a qualified edge loads 1.
    pin = ~d_exp;
    for (int i = 0; i < 6; i++) step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_edge_pulse", int'(rise | fall), 1);
    check("clr_edge_cnt", int'(edge_cnt), 1);
    d_exp = ~d_exp;
    cnt_exp = 2'd1;

    // Clear alone.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_alone", int'(edge_cnt), 0);
    cnt_exp = '0;

    // Enable gating: return to low first if needed.
    if (d_exp) expect_edge("pre_en_fall", 6);
    en   = 1'b0;
    pin  = 1'b1;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (d_out || busy || rise || fall) viol++;
    end
    check("en_off_quiet", viol, 0);
    en = 1'b1;
    run_until_edge(n, r, f, c);
    check("en_rise_clock", n + 1, 5);
    check("en_rise_pulse", int'({r, f}), 2);
    d_exp   = 1'b1;
    cnt_exp = cnt_exp + CW'(1);
    check("en_rise_cnt", int'(c), int'(cnt_exp));
    step();
    expect_edge("pre_rst_fall", 6);

    // Reset asserted mid-qualification (sc == 2).
    pin = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("qual_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", int'(obs()), 0);
    step();
    step();
    rst_n   = 1'b1;
    d_exp   = 1'b0;
    cnt_exp = '0;
    expect_edge("rst_release", 6);

    // Pin held high through reset.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_async_outputs", int'(obs()), 0);
    step();
    step();
    step();
    rst_n   = 1'b1;
    d_exp   = 1'b0;
    cnt_exp = '0;
    pin     = 1'b1;
    run_until_edge(n, r, f, c);
    check("pin_high_rst_step", n, SC + 2);
    check("pin_high_rst_pulse", int'({r, f}), 2);
    check("pin_high_rst_cnt", int'(c), 1);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!d_out || rise || fall || busy) viol++;
    end
    check("pin_high_hold", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
